// File: rtl/px_adc_reader_if.sv
// px_adc_reader_if - bus between a pixel ADC front end and its surroundings.
//   Request side : start (in), busy, overrun, sample, sample_valid (out)
//   ADC pins     : adc_cs, adc_sclk (out), adc_din (in)
// slave  : the front end (px_adc_reader)
// master : the sequencer / capture stage / ADC side that talks to it
interface px_adc_reader_if #(
  parameter int DATA_BITS = 12
);
  logic                 start;
  logic                 busy;
  logic                 overrun;
  logic                 adc_cs;
  logic                 adc_sclk;
  logic                 adc_din;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;

  modport slave (
    input  start, adc_din,
    output busy, overrun, adc_cs, adc_sclk, sample, sample_valid
  );

  modport master (
    output start, adc_din,
    input  busy, overrun, adc_cs, adc_sclk, sample, sample_valid
  );
endinterface

// File: rtl/px_adc_reader.sv
// px_adc_reader - serial pixel ADC front end for one camera channel.
// On a start pulse (accepted only when idle) it runs one conversion frame on
// the external ADC (cs low, FRAME_BITS sclk cycles, CPOL=1) and returns the
// DATA_BITS sample that follows LEAD_BITS discarded leading bits, with a
// one-cycle sample_valid strobe. Every output comes straight from a flop.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      px_adc_reader_if.slave (start/busy/overrun/sample/valid + ADC pins)
// Legal configurations need LEAD_BITS+DATA_BITS <= FRAME_BITS and DATA_BITS >= 2.
module px_adc_reader #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int DATA_BITS  = 12,
  parameter int SCLK_HALF  = 2,
  parameter int CS_QUIET   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  px_adc_reader_if.slave    bus
);

  // One counter times SETUP, each sclk half and QUIET, so size it for the longest.
  localparam int CNT_MAX = (SCLK_HALF > CS_QUIET) ? SCLK_HALF : CS_QUIET;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(FRAME_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(CS_QUIET - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] DATA_LO    = BW'(LEAD_BITS);
  localparam logic [BW-1:0] DATA_HI    = BW'(LEAD_BITS + DATA_BITS);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 cs_q, cs_d;
  logic                 sclk_q, sclk_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    busy_d   = busy_q;
    shreg_d  = shreg_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    // Any start outside IDLE is dropped and flagged, including the cycle
    // that returns to IDLE from QUIET.
    ovr_d    = bus.start && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end

      SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising sclk: the ADC launched this bit on the previous falling
            // edge, so din has been stable for a full half period.
            sclk_d = 1'b1;
            if (bit_q >= DATA_LO && bit_q < DATA_HI)
              shreg_d = {shreg_q[DATA_BITS-2:0], bus.adc_din};
          end else if (bit_q == BIT_LAST) begin
            state_d  = QUIET;
            cs_d     = 1'b1;
            sample_d = shreg_q;
            valid_d  = 1'b1;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end
      end

      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      shreg_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.adc_cs       = cs_q;
  assign bus.adc_sclk     = sclk_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_px_adc_reader.sv
// Bench for px_adc_reader: a default instance (A) and a short-frame instance
// (B: FRAME_BITS=14, LEAD_BITS=2, SCLK_HALF=1, CS_QUIET=1). Each has a
// behavioural ADC that shifts a frame word out MSB first on sclk falling edges.
module tb_px_adc_reader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  px_adc_reader_if #(.DATA_BITS(12)) ia ();
  px_adc_reader_if #(.DATA_BITS(12)) ib ();

  px_adc_reader ua (.clk(clk), .reset_n(reset_n), .bus(ia.slave));
  px_adc_reader #(.FRAME_BITS(14), .LEAD_BITS(2), .DATA_BITS(12),
                  .SCLK_HALF(1), .CS_QUIET(1))
    ub (.clk(clk), .reset_n(reset_n), .bus(ib.slave));

  // ADC models: bit index restarts whenever cs is high.
  logic [15:0] wa = '0, wb = '0;
  int ia_idx = 0, ib_idx = 0;

  always @(negedge ia.adc_sclk or posedge ia.adc_cs)
    if (ia.adc_cs) ia_idx <= 0;
    else begin
      ia.adc_din <= (ia_idx < 16) ? wa[15 - ia_idx] : 1'b0;
      ia_idx <= ia_idx + 1;
    end

  always @(negedge ib.adc_sclk or posedge ib.adc_cs)
    if (ib.adc_cs) ib_idx <= 0;
    else begin
      ib.adc_din <= (ib_idx < 14) ? wb[13 - ib_idx] : 1'b0;
      ib_idx <= ib_idx + 1;
    end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the sample is the DATA field that follows LEAD bits in a
  // FRAME-bit word sent MSB first.
  function automatic logic [11:0] ref_sample(input int fb, input int lead, input logic [15:0] w);
    logic [15:0] t;
    t = w >> (fb - lead - 12);
    return t[11:0];
  endfunction

  function automatic int fb_of(input int which);  return which ? 14 : 16; endfunction
  function automatic int lead_of(input int which); return which ? 2 : 4;  endfunction
  function automatic int sh_of(input int which);  return which ? 1 : 2;  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) ia.start = v; else ib.start = v;
  endtask

  // One frame: start pulse at edge T0; optional second pulse at edge T0+extra_k.
  // Observation k is taken on the falling clock edge after edge T0+k.
  task automatic conv(input int which, input logic [15:0] w, input int extra_k,
                      output int vk, output int nval, output int rises, output int cslow,
                      output int ovk, output int novr, output logic [11:0] smp);
    logic ps, cs, sc, vl, ov, bz;
    logic [11:0] sm;
    if (which == 0) wa = w; else wb = w;
    vk = -1; nval = 0; rises = 0; cslow = 0; ovk = -1; novr = 0; smp = '0; ps = 1'b1;
    @(negedge clk); set_start(which, 1'b1);
    @(negedge clk); set_start(which, 1'b0);
    for (int k = 0; k < 150; k++) begin
      if (which == 0) begin
        cs = ia.adc_cs; sc = ia.adc_sclk; vl = ia.sample_valid; ov = ia.overrun; bz = ia.busy; sm = ia.sample;
      end else begin
        cs = ib.adc_cs; sc = ib.adc_sclk; vl = ib.sample_valid; ov = ib.overrun; bz = ib.busy; sm = ib.sample;
      end
      if (!cs) cslow++;
      if (sc && !ps) rises++;
      ps = sc;
      if (vl) begin nval++; if (vk < 0) begin vk = k; smp = sm; end end
      if (ov) begin novr++; if (ovk < 0) ovk = k; end
      set_start(which, (k + 1 == extra_k));
      if (vk >= 0 && !bz) break;
      @(negedge clk);
    end
    set_start(which, 1'b0);
  endtask

  task automatic conv_check(input string tag, input int which, input logic [15:0] w,
                            input logic [11:0] exp);
    int vk, nv, ri, cl, ok, no;
    logic [11:0] s;
    int lat;
    lat = sh_of(which) * (1 + 2 * fb_of(which));
    conv(which, w, -1, vk, nv, ri, cl, ok, no, s);
    chk({tag, " sample"}, 32'(s), 32'(exp));
    chk({tag, " valid_cycle"}, 32'(vk), 32'(lat));
    chk({tag, " valid_count"}, 32'(nv), 32'd1);
    chk({tag, " sclk_rises"}, 32'(ri), 32'(fb_of(which)));
    chk({tag, " cs_low_cycles"}, 32'(cl), 32'(lat));
    chk({tag, " no_overrun"}, 32'(no), 32'd0);
  endtask

  typedef struct {
    int          which;
    logic [15:0] w;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int vk, nv, ri, cl, ok, no;
    logic [11:0] s;
    logic [15:0] w;
    int first_fall;
    logic busy68, ovr68, cs_before;

    tbl[0] = '{0, 16'h0A5C, 12'hA5C};
    tbl[1] = '{0, 16'hF001, 12'h001};
    tbl[2] = '{0, 16'hFFFF, 12'hFFF};
    tbl[3] = '{0, 16'hF000, 12'h000};
    tbl[4] = '{0, 16'h0800, 12'h800};
    tbl[5] = '{1, 16'h3A5C, 12'hA5C};
    tbl[6] = '{1, 16'h3000, 12'h000};
    tbl[7] = '{1, 16'h0FFF, 12'hFFF};

    ia.start = 1'b0; ib.start = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst cs", 32'(ia.adc_cs), 32'd1);
    chk("rst sclk", 32'(ia.adc_sclk), 32'd1);
    chk("rst busy", 32'(ia.busy), 32'd0);
    chk("rst overrun", 32'(ia.overrun), 32'd0);
    chk("rst sample", 32'(ia.sample), 32'd0);
    chk("rst valid", 32'(ia.sample_valid), 32'd0);
    chk("rst b cs", 32'(ib.adc_cs), 32'd1);
    chk("rst b sample", 32'(ib.sample), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors
    foreach (tbl[i]) conv_check($sformatf("tbl%0d", i), tbl[i].which, tbl[i].w, tbl[i].exp);

    // Randomized vectors vs reference model
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      conv_check($sformatf("rndA%0d", i), 0, w, ref_sample(16, 4, w));
      w = 16'($urandom) & 16'h3FFF;
      conv_check($sformatf("rndB%0d", i), 1, w, ref_sample(14, 2, w));
    end

    // Second start mid-frame: one overrun pulse, frame unaffected
    conv(0, 16'h0123, 10, vk, nv, ri, cl, ok, no, s);
    chk("ovr cycle", 32'(ok), 32'd10);
    chk("ovr count", 32'(no), 32'd1);
    chk("ovr valid_count", 32'(nv), 32'd1);
    chk("ovr sample", 32'(s), 32'(ref_sample(16, 4, 16'h0123)));

    // Start held high: next frame accepted only once idle (T0+69)
    wa = 16'h0ABC;
    first_fall = -1; busy68 = 1'b1; ovr68 = 1'b0;
    @(negedge clk); ia.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 80; k++) begin
      if (k == 68) begin busy68 = ia.busy; ovr68 = ia.overrun; end
      if (k > 66 && !ia.adc_cs && first_fall < 0) first_fall = k;
      @(negedge clk);
    end
    ia.start = 1'b0;
    chk("held next_start", 32'(first_fall), 32'd69);
    chk("held busy_at_68", 32'(busy68), 32'd0);
    chk("held ovr_at_68", 32'(ovr68), 32'd1);
    nv = 0;
    for (int k = 0; k < 100 && ia.busy; k++) begin
      if (ia.sample_valid) nv++;
      @(negedge clk);
    end
    chk("held 2nd idle", 32'(ia.busy), 32'd0);
    chk("held 2nd valid", 32'(nv), 32'd1);
    chk("held 2nd sample", 32'(ia.sample), 32'(ref_sample(16, 4, 16'h0ABC)));

    // Reset mid SHIFT
    conv_check("pre_rst", 0, 16'h0FED, 12'hFED);
    @(negedge clk); ia.start = 1'b1;
    @(negedge clk); ia.start = 1'b0;
    nv = 0;
    for (int k = 0; k < 29; k++) begin
      if (ia.sample_valid) nv++;
      @(negedge clk);
    end
    cs_before = ia.adc_cs;
    reset_n = 1'b0;
    #1;
    chk("midrst cs_was_low", 32'(cs_before), 32'd0);
    chk("midrst no_valid", 32'(nv), 32'd0);
    chk("midrst cs", 32'(ia.adc_cs), 32'd1);
    chk("midrst sclk", 32'(ia.adc_sclk), 32'd1);
    chk("midrst busy", 32'(ia.busy), 32'd0);
    chk("midrst sample", 32'(ia.sample), 32'd0);
    chk("midrst valid", 32'(ia.sample_valid), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    conv_check("post_rst", 0, 16'h0A5C, 12'hA5C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
